mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one RAM port between the instruction-fetch requester (iREN) and the
//  data requester (dREN/dWEN) generated by the control unit. Latches the
//  winning request, holds it on the RAM port until ram_ready, then returns one
//  hit pulse to the winner. Sits between the datapath and the RAM or bus.
//  Data wins by default. An age counter bounds instruction starvation. Halt
//  drains the port.
// PARAMETERS
//  MAX_DBURST  4  consecutive data grants allowed while iREN is pending (1..15)
// PORTS
//  CLK        in   1   system clock, rising edge
//  RST        in   1   synchronous reset, active-high
//  iREN       in   1   instruction read request; held until ihit
//  iaddr      in   32  instruction address (word_t)
//  ihit       out  1   1-cycle pulse: iload is valid
//  iload      out  32  instruction data, registered
//  dREN       in   1   data read request; held until dhit
//  dWEN       in   1   data write request; held until dhit
//  daddr      in   32  data address
//  dstore     in   32  write data
//  dhit       out  1   1-cycle pulse: data access complete; dload valid on reads
//  dload      out  32  read data, registered
//  halt       in   1   CPU halt; sampled every cycle
//  halted     out  1   port drained and idle; sticky until RST
//  ram_ren    out  1   RAM read strobe
//  ram_wen    out  1   RAM write strobe
//  ram_addr   out  32  RAM address; bits [1:0] forced to 2'b00
//  ram_store  out  32  RAM write data
//  ram_load   in   32  RAM read data; valid when ram_ready=1
//  ram_ready  in   1   RAM completes the current access this cycle
// BEHAVIOUR
//  Reset (RST=1 at a CLK edge): state=IDLE; age=0; all outputs 0; latches cleared.
//   Reset during an access abandons it: strobes drop the next cycle, no hit is issued.
//  FSM states: IDLE, IACC, DACC, HALTED.
//   IDLE:
//    halt=1 -> HALTED.
//    else (dREN|dWEN) and not(iREN and age==MAX_DBURST) -> DACC.
//     Latch daddr, dstore and op: write if dWEN, else read.
//    else iREN -> IACC; latch iaddr.
//    else stay in IDLE.
//   IACC/DACC: drive the latched strobe, address and store data every cycle.
//    ram_ready=0 -> stay in the state.
//    ram_ready=1 -> register ram_load into iload/dload; return to IDLE.
//     ihit/dhit = 1 in the following cycle only.
//  Strobes are registered, so ram_ren/ram_wen are low in IDLE and HALTED.
//  Latency: request seen in IDLE at edge N; strobe high from N+1.
//   Hit at N+2 at the earliest (ram_ready in the first access cycle).
//   Minimum repeat period for one requester: 3 cycles.
//  In the hit cycle the FSM is in IDLE. The requester deasserts on the same edge.
//   The arbiter therefore ignores a request that is still high in its hit cycle
//   (no double grant).
//  dREN=1 and dWEN=1 together: treat as a write.
//  Age counter (4 bits):
//   +1 on each DACC grant while iREN=1, saturating at MAX_DBURST.
//   Cleared on each IACC grant, or when iREN=0 in IDLE.
//   age==MAX_DBURST with both requesting: instruction is granted.
//  A requester that drops its request mid-access still receives its hit pulse.
//   The RAM access is never aborted.
//  halt=1 during IACC/DACC: the access completes and its hit is issued.
//   The FSM then goes to HALTED, not IDLE. halt only needs to be high for one cycle.
//  HALTED: halted=1; all requests ignored; outputs held at 0; exit only via RST.
//  iload/dload hold their last value between hits.
//   Reads only: a data write leaves dload unchanged.
// STRUCTURE
//  cpu_types_pkg (shared) holds:
//   word_t.
//   New typedef arbstate_t enum logic [1:0] {IDLE, IACC, DACC, HALTED}.
//   Constant ARB_AGE_W = 4.
//  One sub-module: arb_age_counter (saturating counter with inc, clr and sat
//   outputs). The rest is a single always_ff FSM plus always_comb next state.
// TESTING
//  1. Reset mid-DACC: RST pulsed while ram_ready=0.
//     -> next cycle ram_ren=ram_wen=0, no dhit, state IDLE, halted=0.
//  2. iREN only, iaddr=0x0000_0043, ram_ready=1 in the first access cycle.
//     -> ram_addr=0x40 at N+1; ihit at N+2 with iload=ram_load.
//  3. iREN and dREN both held high, MAX_DBURST=4, RAM always ready.
//     -> grant order D,D,D,D,I,D,D,D,D,I; the instruction is never delayed more than 4 data grants.
//  4. dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ram_ready delayed 3 cycles.
//     -> ram_wen held 3 cycles; dhit on the 4th; dload unchanged.
//  5. halt pulsed during IACC.
//     -> ihit issued, then halted=1; later iREN/dREN produce no strobes or hits.
//  6. Requester drops dREN one cycle into DACC.
//     -> access completes, dhit pulses once, and no second grant follows.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, arbiter FSM state encoding, age-counter width.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IACC   = 2'b01,
      DACC   = 2'b10,
      HALTED = 2'b11
   } arbstate_t;

   localparam int ARB_AGE_W = 4;

   // RAM is word addressed: the byte-offset bits never reach the port.
   function automatic word_t word_align(input word_t addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Saturating grant-age counter: counts data grants made while the instruction
// side waits; sat_o tells the arbiter the instruction side must win next.
module arb_age_counter
   import cpu_types_pkg::*;
#(
   parameter int MAX = 4
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam logic [ARB_AGE_W-1:0] MAX_C = ARB_AGE_W'(MAX);

   logic [ARB_AGE_W-1:0] count_q;
   logic [ARB_AGE_W-1:0] count_d;

   // Clear wins over increment; increment stops at the limit.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != MAX_C)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign sat_o = (count_q == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single RAM port shared between instruction fetch and data access. Data wins
// by default; the age counter forces an instruction grant after MAX_DBURST
// back-to-back data grants. Halt lets any running access finish, then parks.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int MAX_DBURST = 4
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  iREN,
   input  word_t iaddr,
   output logic  ihit,
   output word_t iload,
   input  logic  dREN,
   input  logic  dWEN,
   input  word_t daddr,
   input  word_t dstore,
   output logic  dhit,
   output word_t dload,
   input  logic  halt,
   output logic  halted,
   output logic  ram_ren,
   output logic  ram_wen,
   output word_t ram_addr,
   output word_t ram_store,
   input  word_t ram_load,
   input  logic  ram_ready
);

   arbstate_t state_q, state_d;
   logic      ram_ren_q, ram_ren_d;
   logic      ram_wen_q, ram_wen_d;
   word_t     ram_addr_q, ram_addr_d;
   word_t     ram_store_q, ram_store_d;
   logic      ihit_q, ihit_d;
   logic      dhit_q, dhit_d;
   word_t     iload_q, iload_d;
   word_t     dload_q, dload_d;
   logic      halt_pend_q, halt_pend_d;

   logic      age_inc;
   logic      age_clr;
   logic      age_sat;
   logic      hit_cycle;

   arb_age_counter #(
      .MAX (MAX_DBURST)
   ) u_age (
      .clk_i  (CLK),
      .srst_i (RST),
      .inc_i  (age_inc),
      .clr_i  (age_clr),
      .sat_o  (age_sat)
   );

   // The requester drops its request on the hit edge, so anything still high
   // during a hit cycle is stale and must not be granted again.
   assign hit_cycle = ihit_q | dhit_q;

   // Next-state, grant selection and completion handling.
   always_comb begin
      state_d     = state_q;
      ram_ren_d   = ram_ren_q;
      ram_wen_d   = ram_wen_q;
      ram_addr_d  = ram_addr_q;
      ram_store_d = ram_store_q;
      ihit_d      = 1'b0;
      dhit_d      = 1'b0;
      iload_d     = iload_q;
      dload_d     = dload_q;
      halt_pend_d = halt_pend_q;
      age_inc     = 1'b0;
      age_clr     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!iREN) begin
               age_clr = 1'b1;
            end
            if (halt) begin
               state_d = HALTED;
            end else if (!hit_cycle) begin
               if ((dREN || dWEN) && !(iREN && age_sat)) begin
                  state_d     = DACC;
                  ram_wen_d   = dWEN;
                  ram_ren_d   = !dWEN;
                  ram_addr_d  = word_align(daddr);
                  ram_store_d = dstore;
                  age_inc     = iREN;
               end else if (iREN) begin
                  state_d     = IACC;
                  ram_ren_d   = 1'b1;
                  ram_wen_d   = 1'b0;
                  ram_addr_d  = word_align(iaddr);
                  ram_store_d = '0;
                  age_clr     = 1'b1;
               end
            end
         end
         IACC, DACC: begin
            if (halt) begin
               halt_pend_d = 1'b1;
            end
            if (ram_ready) begin
               if (state_q == IACC) begin
                  ihit_d  = 1'b1;
                  iload_d = ram_load;
               end else begin
                  dhit_d = 1'b1;
                  if (ram_ren_q) begin
                     dload_d = ram_load;
                  end
               end
               ram_ren_d   = 1'b0;
               ram_wen_d   = 1'b0;
               ram_addr_d  = '0;
               ram_store_d = '0;
               halt_pend_d = 1'b0;
               state_d     = (halt || halt_pend_q) ? HALTED : IDLE;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any access in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         ram_ren_q   <= 1'b0;
         ram_wen_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_store_q <= '0;
         ihit_q      <= 1'b0;
         dhit_q      <= 1'b0;
         iload_q     <= '0;
         dload_q     <= '0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ram_ren_q   <= ram_ren_d;
         ram_wen_q   <= ram_wen_d;
         ram_addr_q  <= ram_addr_d;
         ram_store_q <= ram_store_d;
         ihit_q      <= ihit_d;
         dhit_q      <= dhit_d;
         iload_q     <= iload_d;
         dload_q     <= dload_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   assign ram_ren   = ram_ren_q;
   assign ram_wen   = ram_wen_q;
   assign ram_addr  = ram_addr_q;
   assign ram_store = ram_store_q;
   assign ihit      = ihit_q;
   assign dhit      = dhit_q;
   assign iload     = iload_q;
   assign dload     = dload_q;
   // Drained: parked and the final hit pulse (if any) already delivered.
   assign halted    = (state_q == HALTED) && !hit_cycle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MAX_DBURST = 4).
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic  CLK = 1'b0;
   logic  RST;
   logic  iREN, dREN, dWEN, halt, ram_ready;
   word_t iaddr, daddr, dstore, ram_load;
   logic  ihit, dhit, halted, ram_ren, ram_wen;
   word_t iload, dload, ram_addr, ram_store;

   int checks = 0;
   int failures = 0;

   mem_arbiter #(.MAX_DBURST(4)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .ihit      (ihit),
      .iload     (iload),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .dhit      (dhit),
      .dload     (dload),
      .halt      (halt),
      .halted    (halted),
      .ram_ren   (ram_ren),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_store (ram_store),
      .ram_load  (ram_load),
      .ram_ready (ram_ready)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-16s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      string exp_seq;
      byte   got_seq [10];
      int    ngrant;

      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; halt = 0; ram_ready = 0;
      iaddr = '0; daddr = '0; dstore = '0; ram_load = '0;
      tick(); tick();
      check("rst_ren", {31'b0, ram_ren}, 32'd0);
      check("rst_wen", {31'b0, ram_wen}, 32'd0);
      check("rst_hits", {30'b0, ihit, dhit}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_iload", iload, 32'd0);
      check("rst_dload", dload, 32'd0);
      RST = 1'b0;
      tick();

      // 1. reset in the middle of a data access
      dREN = 1; daddr = 32'h200; ram_ready = 0;
      tick();
      check("t1_ren_on", {31'b0, ram_ren}, 32'd1);
      tick();
      RST = 1; dREN = 0;
      tick();
      check("t1_ren_off", {31'b0, ram_ren}, 32'd0);
      check("t1_wen_off", {31'b0, ram_wen}, 32'd0);
      check("t1_no_dhit", {31'b0, dhit}, 32'd0);
      check("t1_halted", {31'b0, halted}, 32'd0);
      RST = 0;
      tick();
      check("t1_no_dhit2", {31'b0, dhit}, 32'd0);
      check("t1_idle_ren", {31'b0, ram_ren}, 32'd0);

      // 2. instruction fetch, RAM ready on first access cycle
      iREN = 1; iaddr = 32'h43; ram_ready = 1; ram_load = 32'hCAFE_0001;
      tick();
      check("t2_ren", {31'b0, ram_ren}, 32'd1);
      check("t2_addr", ram_addr, 32'h40);
      check("t2_ihit_early", {31'b0, ihit}, 32'd0);
      tick();
      check("t2_ihit", {31'b0, ihit}, 32'd1);
      check("t2_iload", iload, 32'hCAFE_0001);
      iREN = 0;
      tick();
      check("t2_ihit_once", {31'b0, ihit}, 32'd0);
      check("t2_no_regrant", {31'b0, ram_ren}, 32'd0);

      // 4a. data read to give dload a known value
      dREN = 1; daddr = 32'h104; ram_ready = 1; ram_load = 32'h5555_AAAA;
      tick();
      check("t4a_ren", {31'b0, ram_ren}, 32'd1);
      tick();
      check("t4a_dhit", {31'b0, dhit}, 32'd1);
      check("t4a_dload", dload, 32'h5555_AAAA);
      dREN = 0; ram_ready = 0;
      tick();

      // 4. write (dREN and dWEN together), RAM ready after 3 cycles
      dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ram_load = 32'h1234_5678;
      tick();
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("t4_wen_c%0d", c), {31'b0, ram_wen}, 32'd1);
         check($sformatf("t4_ren_c%0d", c), {31'b0, ram_ren}, 32'd0);
         check($sformatf("t4_nohit_c%0d", c), {31'b0, dhit}, 32'd0);
         if (c == 3) ram_ready = 1;
         else tick();
      end
      check("t4_addr", ram_addr, 32'h100);
      check("t4_store", ram_store, 32'hDEAD_BEEF);
      tick();
      check("t4_dhit", {31'b0, dhit}, 32'd1);
      check("t4_dload_kept", dload, 32'h5555_AAAA);
      check("t4_wen_off", {31'b0, ram_wen}, 32'd0);
      dREN = 0; dWEN = 0; ram_ready = 0;
      tick();
      check("t4_dhit_once", {31'b0, dhit}, 32'd0);

      // 6. requester drops dREN one cycle into the access
      dREN = 1; daddr = 32'h300; ram_ready = 0; ram_load = 32'h0BAD_F00D;
      tick();
      dREN = 0;
      tick();
      check("t6_ren_held", {31'b0, ram_ren}, 32'd1);
      ram_ready = 1;
      tick();
      check("t6_dhit", {31'b0, dhit}, 32'd1);
      check("t6_dload", dload, 32'h0BAD_F00D);
      ram_ready = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("t6_idle_c%0d", c), {30'b0, ram_ren, ram_wen}, 32'd0);
         check($sformatf("t6_nohit_c%0d", c), {31'b0, dhit}, 32'd0);
      end

      // 3. both requesters held, RAM always ready
      exp_seq = "DDDDIDDDDI";
      iREN = 1; iaddr = 32'h1000; dREN = 1; daddr = 32'h2000; ram_ready = 1;
      ngrant = 0;
      for (int c = 0; c < 40 && ngrant < 10; c++) begin
         tick();
         if (ram_ren) begin
            got_seq[ngrant] = (ram_addr == 32'h1000) ? "I" : "D";
            ngrant++;
         end
      end
      check("t3_grant_count", ngrant, 32'd10);
      for (int k = 0; k < ngrant; k++) begin
         check($sformatf("t3_grant%0d", k), {24'b0, got_seq[k]}, {24'b0, exp_seq[k]});
      end
      iREN = 0; dREN = 0;
      tick(); tick(); tick();

      // 5. halt pulsed during an instruction access
      iREN = 1; iaddr = 32'h500; ram_ready = 0; ram_load = 32'h7777_8888;
      tick();
      check("t5_ren", {31'b0, ram_ren}, 32'd1);
      halt = 1;
      tick();
      halt = 0;
      check("t5_ren_held", {31'b0, ram_ren}, 32'd1);
      check("t5_not_halted", {31'b0, halted}, 32'd0);
      ram_ready = 1;
      tick();
      check("t5_ihit", {31'b0, ihit}, 32'd1);
      check("t5_iload", iload, 32'h7777_8888);
      iREN = 0; ram_ready = 0;
      tick();
      check("t5_halted", {31'b0, halted}, 32'd1);
      check("t5_ihit_once", {31'b0, ihit}, 32'd0);
      iREN = 1; dREN = 1; ram_ready = 1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("t5_nostrobe_c%0d", c), {30'b0, ram_ren, ram_wen}, 32'd0);
         check($sformatf("t5_nohits_c%0d", c), {30'b0, ihit, dhit}, 32'd0);
         check($sformatf("t5_sticky_c%0d", c), {31'b0, halted}, 32'd1);
      end
      iREN = 0; dREN = 0; RST = 1;
      tick();
      check("t5_rst_clears", {31'b0, halted}, 32'd0);
      RST = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
